spi_frame_writer: RTL and testbench

- Upstream stage of the LED transmit path. Receives LED pixel bytes over a mode-0 SPI slave link.
- Packs the bytes into the 64x32 pixel RAM through its byte-enable write port.
- Issues the one-cycle read trigger that starts serial transmission once a frame is complete.
- Defers that trigger while a previous transmission is still in progress.

---
 rtl/spi_frame_writer.sv | 174 +++++++++++++++++
 tb/tb_spi_frame_writer.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_frame_writer.sv
// rtl/spi_frame_writer.sv - SPI slave byte receiver that packs LED pixel bytes into RAM and triggers transmit
//
// Ports:
//   clk        system clock, at least 8x spi_sclk
//   rst_n      asynchronous active-low reset
//   spi_sclk   SPI clock (mode 0, idle low), MOSI sampled on its rising edge
//   spi_mosi   SPI data, MSB first
//   spi_cs_n   SPI chip select, active low, one frame per low period
//   trans_busy downstream serializer is transmitting
//   spi_data   assembled byte, replicated to all RAM lanes downstream
//   byte_en    one-hot RAM byte enable (lane 3 first)
//   wraddress  RAM word address
//   wren       RAM write strobe, one cycle per byte
//   read       transmit trigger pulse, one cycle
//   frame_len  bytes accepted in the last completed frame
//   ovf        sticky overflow of the last frame, cleared at next frame start

module spi_frame_writer #(
    parameter int SYNC_STAGES = 2,
    parameter int ADDR_W      = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              spi_sclk,
    input  logic              spi_mosi,
    input  logic              spi_cs_n,
    input  logic              trans_busy,
    output logic [7:0]        spi_data,
    output logic [3:0]        byte_en,
    output logic [ADDR_W-1:0] wraddress,
    output logic              wren,
    output logic              read,
    output logic [ADDR_W+2:0] frame_len,
    output logic              ovf
);

    localparam int CNT_W = ADDR_W + 3;
    localparam logic [CNT_W-1:0] CAP = CNT_W'(4 << ADDR_W);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic [SYNC_STAGES-1:0] cs_sync;
    logic             sclk_d;
    logic             cs_d;
    logic [SYNC_STAGES:0] settle;

    logic [7:0]       shift_reg;
    logic [2:0]       bit_cnt;
    logic [CNT_W-1:0] byte_cnt;
    logic             pending;

    logic             sclk_s;
    logic             mosi_s;
    logic             cs_s;
    logic             settled;
    logic             sclk_rise;
    logic             cs_fall;
    logic             cs_rise;
    logic [7:0]       next_shift;
    logic             byte_done;
    logic             wr_now;
    logic [CNT_W-1:0] cnt_after;

    // Synchronizers. cs_n presets high and sclk low so reset looks like an idle bus.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync <= '0;
            mosi_sync <= '0;
            cs_sync   <= '1;
            sclk_d    <= 1'b0;
            cs_d      <= 1'b1;
            settle    <= '0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_sclk};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n};
            sclk_d    <= sclk_s;
            cs_d      <= cs_s;
            settle    <= {settle[SYNC_STAGES-1:0], 1'b1};
        end
    end

    // Edges are masked until the pipeline has flushed the reset preset; otherwise a
    // cs_n held low through reset release would look like a falling edge.
    always_comb begin
        sclk_s     = sclk_sync[SYNC_STAGES-1];
        mosi_s     = mosi_sync[SYNC_STAGES-1];
        cs_s       = cs_sync[SYNC_STAGES-1];
        settled    = settle[SYNC_STAGES];
        sclk_rise  = settled & sclk_s & ~sclk_d;
        cs_fall    = settled & ~cs_s & cs_d;
        cs_rise    = settled & cs_s & ~cs_d;
        next_shift = {shift_reg[6:0], mosi_s};
        byte_done  = (state == RECV) && sclk_rise && (bit_cnt == 3'd7);
        wr_now     = byte_done && (byte_cnt < CAP);
        cnt_after  = byte_cnt + CNT_W'(wr_now);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            shift_reg <= '0;
            bit_cnt   <= '0;
            byte_cnt  <= '0;
            pending   <= 1'b0;
            spi_data  <= '0;
            byte_en   <= '0;
            wraddress <= '0;
            wren      <= 1'b0;
            read      <= 1'b0;
            frame_len <= '0;
            ovf       <= 1'b0;
        end else begin
            wren <= 1'b0;
            read <= 1'b0;
            case (state)
                IDLE: begin
                    if (cs_fall) begin
                        byte_cnt <= '0;
                        bit_cnt  <= '0;
                        ovf      <= 1'b0;
                        state    <= RECV;
                    end
                end
                RECV: begin
                    if (sclk_rise) begin
                        shift_reg <= next_shift;
                        bit_cnt   <= bit_cnt + 3'd1;
                    end
                    if (wr_now) begin
                        spi_data  <= next_shift;
                        wraddress <= byte_cnt[ADDR_W+1:2];
                        byte_en   <= 4'b1000 >> byte_cnt[1:0];
                        wren      <= 1'b1;
                        byte_cnt  <= cnt_after;
                    end else if (byte_done) begin
                        ovf <= 1'b1;
                    end
                    // A byte finishing on the same cycle as cs_n rising is still counted.
                    if (cs_rise) begin
                        frame_len <= cnt_after;
                        bit_cnt   <= '0;
                        state     <= (cnt_after == '0) ? IDLE : DONE;
                    end
                end
                DONE: begin
                    // A new frame start abandons the deferred trigger.
                    if (cs_fall) begin
                        byte_cnt <= '0;
                        bit_cnt  <= '0;
                        ovf      <= 1'b0;
                        pending  <= 1'b0;
                        state    <= RECV;
                    end else if (!trans_busy) begin
                        read    <= 1'b1;
                        pending <= 1'b0;
                        state   <= IDLE;
                    end else if (!pending) begin
                        pending <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_frame_writer.sv
// tb/tb_spi_frame_writer.sv - randomized self-checking bench for spi_frame_writer
module tb_spi_frame_writer;

    localparam time HALF = 50ns;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       spi_sclk = 1'b0;
    logic       spi_mosi = 1'b0;
    logic       spi_cs_n = 1'b1;
    logic       trans_busy = 1'b0;
    logic [7:0] spi_data;
    logic [3:0] byte_en;
    logic [5:0] wraddress;
    logic       wren;
    logic       read;
    logic [8:0] frame_len;
    logic       ovf;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int read_cnt = 0;
    int read_cyc = 0;
    logic [7:0] got_data[$];
    logic [5:0] got_addr[$];
    logic [3:0] got_be[$];
    logic [7:0] sent[$];

    spi_frame_writer #(.SYNC_STAGES(2), .ADDR_W(6)) dut (
        .clk(clk), .rst_n(rst_n), .spi_sclk(spi_sclk), .spi_mosi(spi_mosi),
        .spi_cs_n(spi_cs_n), .trans_busy(trans_busy), .spi_data(spi_data),
        .byte_en(byte_en), .wraddress(wraddress), .wren(wren), .read(read),
        .frame_len(frame_len), .ovf(ovf)
    );

    always #5ns clk = ~clk;
    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (wren) begin
            got_data.push_back(spi_data);
            got_addr.push_back(wraddress);
            got_be.push_back(byte_en);
        end
        if (read) begin
            read_cnt++;
            read_cyc = cyc;
        end
    end

    task automatic clear_mon();
        got_data.delete();
        got_addr.delete();
        got_be.delete();
        read_cnt = 0;
    endtask

    task automatic send_bits(input logic [7:0] v, input int nb);
        for (int i = 7; i >= 8 - nb; i--) begin
            spi_mosi = v[i];
            #HALF spi_sclk = 1'b1;
            #HALF spi_sclk = 1'b0;
        end
    endtask

    task automatic send_frame();
        spi_cs_n = 1'b0;
        #(2 * HALF);
        foreach (sent[i]) send_bits(sent[i], 8);
        #HALF spi_cs_n = 1'b1;
        repeat (20) @(posedge clk);
    endtask

    task automatic fill_random(input int n);
        sent.delete();
        for (int i = 0; i < n; i++) sent.push_back(8'($urandom_range(0, 255)));
    endtask

    task automatic test_reset();
        #20ns;
        checks++; if (spi_data !== 8'h00) begin failures++; $display("FAIL reset_spi_data got=%h exp=00", spi_data); end
        checks++; if (byte_en !== 4'h0) begin failures++; $display("FAIL reset_byte_en got=%h exp=0", byte_en); end
        checks++; if (wraddress !== 6'd0) begin failures++; $display("FAIL reset_wraddress got=%0d exp=0", wraddress); end
        checks++; if (wren !== 1'b0) begin failures++; $display("FAIL reset_wren got=%b exp=0", wren); end
        checks++; if (read !== 1'b0) begin failures++; $display("FAIL reset_read got=%b exp=0", read); end
        checks++; if (frame_len !== 9'd0) begin failures++; $display("FAIL reset_frame_len got=%0d exp=0", frame_len); end
        checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
        @(negedge clk) rst_n = 1'b1;
        repeat (10) @(posedge clk);
    endtask

    task automatic test_four_bytes();
        sent.delete();
        sent.push_back(8'h12); sent.push_back(8'h34); sent.push_back(8'h56); sent.push_back(8'h78);
        clear_mon();
        send_frame();
        checks++; if (got_data.size() != 4) begin failures++; $display("FAIL four_wr_count got=%0d exp=4", got_data.size()); end
        for (int i = 0; i < 4 && i < got_data.size(); i++) begin
            checks++;
            if (got_data[i] !== sent[i] || got_addr[i] !== 6'd0 || got_be[i] !== 4'(1 << (3 - i))) begin
                failures++;
                $display("FAIL four_write[%0d] got=%h/%0d/%b exp=%h/0/%b", i, got_data[i], got_addr[i], got_be[i], sent[i], 4'(1 << (3 - i)));
            end
        end
        checks++; if (read_cnt != 1) begin failures++; $display("FAIL four_read_count got=%0d exp=1", read_cnt); end
        checks++; if (frame_len !== 9'd4) begin failures++; $display("FAIL four_frame_len got=%0d exp=4", frame_len); end
    endtask

    task automatic test_random_frames();
        int lens[4] = '{7, 1, 13, 20};
        foreach (lens[f]) begin
            fill_random(lens[f]);
            clear_mon();
            send_frame();
            checks++;
            if (got_data.size() != lens[f]) begin
                failures++; $display("FAIL rand%0d_wr_count got=%0d exp=%0d", f, got_data.size(), lens[f]);
            end
            for (int i = 0; i < lens[f] && i < got_data.size(); i++) begin
                checks++;
                if (got_data[i] !== sent[i] || got_addr[i] !== 6'(i / 4) || got_be[i] !== 4'(1 << (3 - i % 4))) begin
                    failures++;
                    $display("FAIL rand%0d_write[%0d] got=%h/%0d/%b exp=%h/%0d/%b", f, i, got_data[i], got_addr[i], got_be[i], sent[i], i / 4, 4'(1 << (3 - i % 4)));
                end
            end
            checks++; if (read_cnt != 1) begin failures++; $display("FAIL rand%0d_read_count got=%0d exp=1", f, read_cnt); end
            checks++; if (frame_len !== 9'(lens[f])) begin failures++; $display("FAIL rand%0d_frame_len got=%0d exp=%0d", f, frame_len, lens[f]); end
        end
    endtask

    task automatic test_overflow();
        int bad = 0;
        fill_random(258);
        clear_mon();
        send_frame();
        checks++; if (got_data.size() != 256) begin failures++; $display("FAIL ovf_wr_count got=%0d exp=256", got_data.size()); end
        for (int i = 0; i < 256 && i < got_data.size(); i++)
            if (got_data[i] !== sent[i] || got_addr[i] !== 6'(i / 4) || got_be[i] !== 4'(1 << (3 - i % 4))) bad++;
        checks++; if (bad != 0) begin failures++; $display("FAIL ovf_write_contents got=%0d bad writes exp=0", bad); end
        if (got_data.size() > 0) begin
            checks++;
            if (got_addr[$] !== 6'd63 || got_be[$] !== 4'b0001) begin
                failures++; $display("FAIL ovf_last_write got=%0d/%b exp=63/0001", got_addr[$], got_be[$]);
            end
        end
        checks++; if (ovf !== 1'b1) begin failures++; $display("FAIL ovf_flag got=%b exp=1", ovf); end
        checks++; if (frame_len !== 9'd256) begin failures++; $display("FAIL ovf_frame_len got=%0d exp=256", frame_len); end
        checks++; if (read_cnt != 1) begin failures++; $display("FAIL ovf_read_count got=%0d exp=1", read_cnt); end
    endtask

    task automatic test_busy();
        int fall_cyc;
        fill_random(3);
        clear_mon();
        trans_busy = 1'b1;
        send_frame();
        checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL busy_ovf_cleared got=%b exp=0", ovf); end
        repeat (30) @(posedge clk);
        checks++; if (read_cnt != 0) begin failures++; $display("FAIL busy_read_while_busy got=%0d exp=0", read_cnt); end
        @(posedge clk);
        #1ns trans_busy = 1'b0;
        fall_cyc = cyc;
        repeat (10) @(posedge clk);
        checks++; if (read_cnt != 1) begin failures++; $display("FAIL busy_read_count got=%0d exp=1", read_cnt); end
        checks++; if (read_cyc != fall_cyc + 1) begin failures++; $display("FAIL busy_read_timing got=%0d exp=%0d", read_cyc, fall_cyc + 1); end
        checks++; if (got_data.size() != 3) begin failures++; $display("FAIL busy_wr_count got=%0d exp=3", got_data.size()); end
    endtask

    task automatic test_partial();
        logic [7:0] b0, b1;
        b0 = 8'($urandom_range(0, 255));
        b1 = 8'($urandom_range(0, 255));
        clear_mon();
        spi_cs_n = 1'b0;
        #(2 * HALF);
        send_bits(b0, 8);
        send_bits(b1, 4);
        #HALF spi_cs_n = 1'b1;
        repeat (20) @(posedge clk);
        checks++; if (got_data.size() != 1) begin failures++; $display("FAIL partial_wr_count got=%0d exp=1", got_data.size()); end
        else begin
            checks++; if (got_data[0] !== b0) begin failures++; $display("FAIL partial_data got=%h exp=%h", got_data[0], b0); end
        end
        checks++; if (frame_len !== 9'd1) begin failures++; $display("FAIL partial_frame_len got=%0d exp=1", frame_len); end
        checks++; if (read_cnt != 1) begin failures++; $display("FAIL partial_read_count got=%0d exp=1", read_cnt); end
        clear_mon();
        spi_cs_n = 1'b0;
        #(2 * HALF);
        send_bits(b1, 5);
        #HALF spi_cs_n = 1'b1;
        repeat (20) @(posedge clk);
        checks++; if (got_data.size() != 0) begin failures++; $display("FAIL empty_wr_count got=%0d exp=0", got_data.size()); end
        checks++; if (read_cnt != 0) begin failures++; $display("FAIL empty_read_count got=%0d exp=0", read_cnt); end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] b;
        b = 8'($urandom_range(0, 255));
        spi_cs_n = 1'b0;
        #(2 * HALF);
        send_bits(8'hA5, 5);
        #17ns rst_n = 1'b0;
        #1ns;
        checks++;
        if (spi_data !== 8'h00 || byte_en !== 4'h0 || wraddress !== 6'd0 || wren !== 1'b0 || read !== 1'b0 || frame_len !== 9'd0 || ovf !== 1'b0) begin
            failures++;
            $display("FAIL midreset_outputs got=%h/%b/%0d/%b/%b/%0d/%b exp=all zero", spi_data, byte_en, wraddress, wren, read, frame_len, ovf);
        end
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        clear_mon();
        repeat (5) @(posedge clk);
        send_bits(8'h3C, 8);
        send_bits(8'hC3, 8);
        repeat (20) @(posedge clk);
        checks++; if (got_data.size() != 0) begin failures++; $display("FAIL midreset_no_write got=%0d exp=0", got_data.size()); end
        spi_cs_n = 1'b1;
        repeat (20) @(posedge clk);
        checks++; if (read_cnt != 0) begin failures++; $display("FAIL midreset_no_read got=%0d exp=0", read_cnt); end
        sent.delete();
        sent.push_back(b);
        send_frame();
        checks++;
        if (got_data.size() != 1 || got_data[0] !== b || got_addr[0] !== 6'd0 || got_be[0] !== 4'b1000) begin
            failures++; $display("FAIL midreset_fresh_frame got=%0d writes exp=1 write of %h at 0/1000", got_data.size(), b);
        end
        checks++; if (read_cnt != 1) begin failures++; $display("FAIL midreset_fresh_read got=%0d exp=1", read_cnt); end
    endtask

    initial begin
        test_reset();
        test_four_bytes();
        test_random_frames();
        test_overflow();
        test_busy();
        test_partial();
        test_reset_mid_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
